// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
// Signed mode is selected with the BIN2BCD_SIGNED_EN macro (see bin2bcd_iter).
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_VALUE     = 4'd3;

    // Wide enough to count from 0 up to and including bin_w.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_iter_if.sv
// Request/result bundle of bin2bcd_iter; master drives Start/Data_Bin, slave returns the result.
interface bin2bcd_iter_if
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);

    logic                          Start;
    logic [BIN_W-1:0]              Data_Bin;
    logic                          Busy;
    logic                          Done;
    logic [BCD_DIGIT_W*DIGITS-1:0] Data_BCD;
    logic                          Sign;
    logic                          Ovf;

    modport master (
        output Start, Data_Bin,
        input  Busy, Done, Data_BCD, Sign, Ovf
    );

    modport slave (
        input  Start, Data_Bin,
        output Busy, Done, Data_BCD, Sign, Ovf
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: digits of 5 or more get +3 before the shift.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= ADD3_THRESHOLD) ? (digit_in + ADD3_VALUE) : digit_in;

endmodule

// File: rtl/bin2bcd_iter.sv
// Iterative (one bit per cycle) double-dabble binary-to-BCD converter.
// Define BIN2BCD_SIGNED_EN to treat Data_Bin as two's complement and report Sign.
module bin2bcd_iter
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input logic           Sys_CLK,
    input logic           Sys_RST,
    bin2bcd_iter_if.slave bus
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(BIN_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

    state_t           state;
    logic [BIN_W-1:0] shreg;
    logic [BIN_W-1:0] load_val;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] adj_acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;

`ifdef BIN2BCD_SIGNED_EN
    logic sign_acc;

    // The magnitude is taken as unsigned BIN_W bits, so the most negative value fits.
    assign load_val = bus.Data_Bin[BIN_W-1] ? (~bus.Data_Bin + BIN_W'(1)) : bus.Data_Bin;
`else
    assign load_val = bus.Data_Bin;
    assign bus.Sign = 1'b0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .digit_in  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (adj_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            state        <= IDLE;
            shreg        <= '0;
            acc          <= '0;
            cnt          <= '0;
            ovf_acc      <= 1'b0;
            bus.Busy     <= 1'b0;
            bus.Done     <= 1'b0;
            bus.Data_BCD <= '0;
            bus.Ovf      <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_acc     <= 1'b0;
            bus.Sign     <= 1'b0;
`endif
        end else begin
            bus.Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        shreg    <= load_val;
                        acc      <= '0;
                        cnt      <= '0;
                        ovf_acc  <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
                        sign_acc <= bus.Data_Bin[BIN_W-1];
`endif
                        bus.Busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Anything leaving the top digit means the value needs more digits.
                    acc     <= {adj_acc[ACC_W-2:0], shreg[BIN_W-1]};
                    shreg   <= {shreg[BIN_W-2:0], 1'b0};
                    ovf_acc <= ovf_acc | adj_acc[ACC_W-1];
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.Data_BCD <= acc;
                    bus.Ovf      <= ovf_acc;
`ifdef BIN2BCD_SIGNED_EN
                    bus.Sign     <= sign_acc;
`endif
                    bus.Done     <= 1'b1;
                    bus.Busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    bus.Busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bin2bcd_iter.md
BIN2BCD_ITER -- requirements
Module: bin2bcd_iter

Interface
REQ-001 The block SHALL have parameter BIN_W, default 16, giving the binary input width (range 4..32).
REQ-002 The block SHALL have parameter DIGITS, default 5, giving the number of BCD output digits (range 1..10).
REQ-003 Sys_CLK  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 Sys_RST  input  1  reset; it SHALL be synchronous and active-high.
REQ-005 Start  input  1  request a conversion of Data_Bin; sampled only while Busy=0.
REQ-006 Data_Bin  input  BIN_W  binary value to convert; sampled in the cycle Start is accepted.
REQ-007 Busy  output  1  high while a conversion is in progress.
REQ-008 Done  output  1  one-cycle pulse marking new Data_BCD, Sign and Ovf values.
REQ-009 Data_BCD  output  4*DIGITS  packed BCD result, with the most significant digit in the top nibble.
REQ-010 Sign  output  1  high when the converted value is negative (signed mode only).
REQ-011 Ovf  output  1  high when the magnitude exceeds 10^DIGITS-1.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 IDLE: when Start=1, the block SHALL load Data_Bin into the shift register, clear the BCD accumulator and the bit counter, and go to SHIFT.
REQ-014 SHIFT, every cycle: each digit >=5 SHALL get +3; then {accumulator, shift register} SHALL shift left by 1; the counter SHALL increment.
REQ-015 SHIFT SHALL last exactly BIN_W cycles and then go to DONE.
REQ-016 DONE SHALL register Data_BCD, Sign and Ovf, pulse Done for one cycle, and return to IDLE.
REQ-017 Latency: Start accepted at edge N -> Done=1 in the cycle after edge N+BIN_W+1.
REQ-018 Throughput: the next Start SHALL be accepted in the first IDLE cycle after DONE.
REQ-019 Busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-020 Start while Busy=1 SHALL be ignored, with no queuing.
REQ-021 Data_Bin changes during SHIFT SHALL have no effect.
REQ-022 Ovf SHALL be set when any 1 is shifted out of the top digit during the conversion; Data_BCD then holds the low DIGITS digits, truncated.
REQ-023 Data_BCD, Sign and Ovf SHALL hold their values between Done pulses.
REQ-024 Input 0 SHALL yield all-zero digits with Ovf=0.

Reset
REQ-025 When Sys_RST=1, the FSM SHALL go to IDLE and Busy, Done, Sign and Ovf SHALL be 0; Data_BCD SHALL be 0; the counter and accumulator SHALL be 0.
REQ-026 Reset asserted mid-SHIFT SHALL abort the conversion with no Done pulse.
REQ-027 Reset SHALL take priority over Start in the same cycle.

Configuration
REQ-028 The macro BIN2BCD_SIGNED_EN SHALL control signed mode.
REQ-029 With BIN2BCD_SIGNED_EN defined, Data_Bin SHALL be treated as two's complement: Sign = the MSB, the magnitude is computed at load, and the most negative value converts to its full magnitude (0x8000 -> 32768 at BIN_W=16).
REQ-030 Without BIN2BCD_SIGNED_EN, Data_Bin SHALL be unsigned, Sign SHALL be tied to 0, and no negation logic SHALL exist.

Structure
REQ-031 Package bin2bcd_pkg SHALL hold the FSM state encoding, the add-3 threshold constant (5), the BCD digit width constant (4), and the counter width function clog2(BIN_W+1).
REQ-032 Sub-module bcd_digit_adj SHALL implement the per-digit combinational add-3 and SHALL be instantiated DIGITS times in a generate loop.
REQ-033 The FSM, counter and shift register SHALL reside in bin2bcd_iter.

Verification
REQ-034 With defaults, Data_Bin=16'h0080 and Start -> Done 18 cycles later, Data_BCD=20'h00128, Ovf=0.
REQ-035 With defaults, Data_Bin=16'hFFFF -> Data_BCD=20'h65535, Ovf=0; Data_Bin=0 -> 20'h00000.
REQ-036 With BIN_W=8 and DIGITS=2, Data_Bin=200 -> Ovf=1 and Data_BCD=8'h00.
REQ-037 Start is pulsed again 5 cycles into a conversion with a new Data_Bin -> only the first result appears, with a single Done.
REQ-038 Sys_RST is pulsed 8 cycles into a conversion -> no Done, all outputs 0, and a following Start of 16'd9999 -> 20'h09999.
REQ-039 With BIN2BCD_SIGNED_EN, Data_Bin=16'hFF85 (-123) -> Sign=1 and Data_BCD=20'h00123; Data_Bin=16'h8000 -> Sign=1 and Data_BCD=20'h32768.
